// File: rtl/ir_fetch_unit.sv
// rtl/ir_fetch_unit.sv - PIC10F200 fetch stage: Q1..Q4 sequencer and prefetch/IR pipeline
// Optional single-instruction stepping when IR_FETCH_STEP_EN is defined.
module ir_fetch_unit #(
    parameter int                  IR_WIDTH = 12,
    parameter logic [IR_WIDTH-1:0] NOP_WORD = 12'h000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
`ifdef IR_FETCH_STEP_EN
    input  logic                step,
`endif
    input  logic [IR_WIDTH-1:0] rom_data,
    input  logic                flush,
    output logic [IR_WIDTH-1:0] ir_bus,
    output logic [1:0]          q_phase,
    output logic                pc_inc,
    output logic                fetch_valid
);

    logic [1:0]          phase_q;
    logic [IR_WIDTH-1:0] pf_q;
    logic                pf_valid_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic                fetch_valid_q;
    logic                flush_pend_q;
    logic                run;
    logic                q4_edge;

`ifdef IR_FETCH_STEP_EN
    logic step_active_q;

    // A step pulse while halted arms exactly one pass through the rest of the
    // instruction cycle; it disarms on the Q4 edge so the core stops at Q1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_active_q <= 1'b0;
        end else if (step_active_q) begin
            if (phase_q == 2'd3) begin
                step_active_q <= 1'b0;
            end
        end else if (step && !en) begin
            step_active_q <= 1'b1;
        end
    end

    assign run = en | step_active_q;
`else
    assign run = en;
`endif

    assign q4_edge = run && (phase_q == 2'd3);

    // Phase sequencer and two-stage fetch pipeline; everything freezes when not running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q       <= 2'd0;
            pf_q          <= NOP_WORD;
            pf_valid_q    <= 1'b0;
            ir_q          <= NOP_WORD;
            fetch_valid_q <= 1'b0;
            flush_pend_q  <= 1'b0;
        end else if (run) begin
            phase_q <= phase_q + 2'd1;
            if (q4_edge) begin
                // The word sampled now is either the next sequential word or the
                // branch target; either way it is genuine and goes to prefetch.
                pf_q         <= rom_data;
                pf_valid_q   <= 1'b1;
                flush_pend_q <= 1'b0;
                if (flush_pend_q || flush) begin
                    ir_q          <= NOP_WORD;
                    fetch_valid_q <= 1'b0;
                end else begin
                    ir_q          <= pf_q;
                    fetch_valid_q <= pf_valid_q;
                end
            end else if (flush) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

    assign ir_bus      = ir_q;
    assign q_phase     = phase_q;
    assign fetch_valid = fetch_valid_q;
    assign pc_inc      = q4_edge;

endmodule

// File: tb/tb_ir_fetch_unit.sv
// tb/tb_ir_fetch_unit.sv - randomized self-checking bench for ir_fetch_unit
module tb_ir_fetch_unit;

    localparam logic [11:0] NOP = 12'h000;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] rom_data;
    logic        flush;
    logic [11:0] ir_bus;
    logic [1:0]  q_phase;
    logic        pc_inc;
    logic        fetch_valid;

    int vectors;
    int miscompares;

    ir_fetch_unit #(.IR_WIDTH(12), .NOP_WORD(12'h000)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rom_data   (rom_data),
        .flush      (flush),
        .ir_bus     (ir_bus),
        .q_phase    (q_phase),
        .pc_inc     (pc_inc),
        .fetch_valid(fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model at instruction-cycle level: a queue of words waiting to
    // execute, a count of running clocks, and a per-cycle "branch seen" flag.
    typedef struct {
        logic [11:0] w;
        bit          v;
    } ent_t;

    ent_t        fq[$];
    int          run_clks;
    bit          flushed;
    logic [11:0] m_ir;
    bit          m_fv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            fq.push_back('{NOP, 1'b0});
            run_clks = 0;
            flushed  = 1'b0;
            m_ir     = NOP;
            m_fv     = 1'b0;
        end else if (en) begin
            ent_t head;
            if (flush) flushed = 1'b1;
            if (run_clks % 4 == 3) begin
                head = fq.pop_front();
                fq.push_back('{rom_data, 1'b1});
                if (flushed) begin
                    m_ir = NOP;
                    m_fv = 1'b0;
                end else begin
                    m_ir = head.w;
                    m_fv = head.v;
                end
                flushed = 1'b0;
            end
            run_clks++;
        end
    end

    // Single compare process: outputs are checked every falling edge.
    always @(negedge clk) begin
        chk("ir_bus", int'(ir_bus), int'(m_ir));
        chk("fetch_valid", int'(fetch_valid), int'(m_fv));
        chk("q_phase", int'(q_phase), run_clks % 4);
        chk("pc_inc", int'(pc_inc), int'(en && (run_clks % 4 == 3)));
    end

    task automatic clk1();
        @(negedge clk);
        #2;
    endtask

    task automatic clkn(input int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        en       = 1'b0;
        flush    = 1'b0;
        rom_data = 12'h000;
        #3;
        chk("reset_ir", int'(ir_bus), 12'h000);
        chk("reset_phase", int'(q_phase), 0);
        chk("reset_fv", int'(fetch_valid), 0);
        chk("reset_pcinc", int'(pc_inc), 0);
        clk1();
        rst      = 1'b0;
        en       = 1'b1;
        rom_data = 12'hA05;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("seq_phase", int'(q_phase), i);
            chk("seq_pcinc", int'(pc_inc), int'(i == 3));
            clk1();
        end
        chk("q4_1_ir", int'(ir_bus), 12'h000);
        chk("q4_1_fv", int'(fetch_valid), 0);
        chk("wrap_phase", int'(q_phase), 0);
        rom_data = 12'h0C3;
        clkn(4);
        chk("q4_2_ir", int'(ir_bus), 12'hA05);
        chk("q4_2_fv", int'(fetch_valid), 1);
        // Branch taken in Q2 while the prefetch register holds 0C3.
        rom_data = 12'h3F1;
        clk1();
        flush = 1'b1;
        clk1();
        flush = 1'b0;
        clkn(2);
        chk("flush_ir", int'(ir_bus), 12'h000);
        chk("flush_fv", int'(fetch_valid), 0);
        clkn(4);
        chk("target_ir", int'(ir_bus), 12'h3F1);
        chk("target_fv", int'(fetch_valid), 1);
        // Halt at Q2 with a flush pulsed during the halt.
        clk1();
        en    = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clk1();
            chk("halt_phase", int'(q_phase), 1);
            chk("halt_ir", int'(ir_bus), 12'h3F1);
            chk("halt_pcinc", int'(pc_inc), 0);
        end
        flush = 1'b0;
        en    = 1'b1;
        clkn(3);
        chk("resume_ir", int'(ir_bus), 12'h3F1);
        chk("resume_fv", int'(fetch_valid), 1);
        // Reset at Q3 with a branch pending.
        clk1();
        flush = 1'b1;
        clk1();
        flush = 1'b0;
        chk("pre_rst_phase", int'(q_phase), 2);
        rst = 1'b1;
        #1;
        chk("async_ir", int'(ir_bus), 12'h000);
        chk("async_phase", int'(q_phase), 0);
        chk("async_fv", int'(fetch_valid), 0);
        clk1();
        rst      = 1'b0;
        rom_data = 12'h111;
        clkn(4);
        chk("post_rst_ir1", int'(ir_bus), 12'h000);
        rom_data = 12'h222;
        clkn(4);
        chk("post_rst_ir2", int'(ir_bus), 12'h111);
        chk("post_rst_fv2", int'(fetch_valid), 1);
        // Randomized run, model-checked every cycle.
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 399) == 0);
            en       = ($urandom_range(0, 7) != 0);
            flush    = ($urandom_range(0, 9) == 0);
            rom_data = 12'($urandom());
            clk1();
        end
        rst = 1'b0;
        clk1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
